muxnway_rr: RTL and testbench

- Parametrised N-way, W-bit registered multiplexer with per-channel valid/ready handshakes and a 1-entry output register.
- Two selection modes:
  - Fixed mode: an externally supplied select chooses the channel.
  - Round-robin mode: the block arbitrates among requesting channels itself.
- Sits between multiple data producers (RAM banks, I/O ports) and a single consumer on the Hack datapath. It is the sequential, flow-controlled generalisation of the 8-way 16-bit mux.

---
 rtl/muxnway_rr.sv | 112 +++++++++++
 tb/tb_muxnway_rr.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxnway_rr.sv
// muxnway_rr: N-way registered valid/ready mux with fixed or round-robin select; define MUXNWAY_RR_LOCK_EN for packet lock
module muxnway_rr #(
  parameter int WIDTH = 16,
  parameter int WAYS = 8,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
`ifdef MUXNWAY_RR_LOCK_EN
  input  logic [WAYS-1:0]       in_last,
  output logic                  out_last,
`endif
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_sel, r_ptr, w_idx, w_rr_idx;
  logic w_load, w_gnt, w_fix_hit, w_rr_hit;
`ifdef MUXNWAY_RR_LOCK_EN
  logic r_last, r_lock;
  logic [SEL_W-1:0] r_lock_ch;
`endif

  function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return SEL_W'(s >= WAYS ? s - WAYS : s);
  endfunction

  // fixed select hits only an in-range channel that is valid
  always_comb begin
    w_fix_hit = 1'b0;
    for (int i = 0; i < WAYS; i++) if (sel == SEL_W'(i)) w_fix_hit = in_valid[i];
  end

  // round-robin: nearest valid channel after r_ptr wins; a held lock overrides the search
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int k = WAYS; k >= 1; k--)
      if (in_valid[f_wrap(r_ptr, k)]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = f_wrap(r_ptr, k);
      end
`ifdef MUXNWAY_RR_LOCK_EN
    if (r_lock) begin
      w_rr_hit = in_valid[r_lock_ch];
      w_rr_idx = r_lock_ch;
    end
`endif
  end

  // load/grant decision, one-hot ready and output register next state
  always_comb begin
    w_load = (r_state == EMPTY) | out_ready;
    w_gnt = w_load & (mode ? w_rr_hit : w_fix_hit);
    w_idx = mode ? w_rr_idx : sel;
    in_ready = w_gnt ? (WAYS'(1) << w_idx) : '0;
    w_state_nxt = w_gnt ? FULL : (w_load ? EMPTY : r_state);
  end

  // output register occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_state_nxt;

  // capture granted beat; round-robin grants advance the pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data <= '0;
      r_sel <= '0;
      r_ptr <= SEL_W'(WAYS - 1);
`ifdef MUXNWAY_RR_LOCK_EN
      r_last <= 1'b0;
`endif
    end else if (w_gnt) begin
      r_data <= in_data[w_idx*WIDTH +: WIDTH];
      r_sel <= w_idx;
      if (mode) r_ptr <= w_idx;
`ifdef MUXNWAY_RR_LOCK_EN
      r_last <= in_last[w_idx];
`endif
    end

`ifdef MUXNWAY_RR_LOCK_EN
  // packet lock holds the arbiter on one channel until its last beat is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_lock_ch <= '0;
    end else if (!mode) r_lock <= 1'b0;
    else if (w_gnt) begin
      r_lock <= ~in_last[w_idx];
      r_lock_ch <= w_idx;
    end

  assign out_last = r_last;
`endif

  assign out_valid = (r_state == FULL);
  assign out_data = r_data;
  assign out_sel = r_sel;
endmodule

// File: tb/tb_muxnway_rr.sv
// tb_muxnway_rr: randomized and directed checks of muxnway_rr against a behavioural model
module tb_muxnway_rr;
  localparam int W = 16;
  localparam int N = 8;
  localparam int N6 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_ready;
  logic mode = 1'b0, out_ready = 1'b0, out_valid;
  logic [2:0] sel = '0, out_sel;
  logic [W-1:0] out_data;
`ifdef MUXNWAY_RR_LOCK_EN
  logic [N-1:0] in_last = '0;
  logic out_last;
  logic m_last;
`endif

  logic [N6*W-1:0] in_data6 = '0;
  logic [N6-1:0] in_valid6 = '0, in_ready6;
  logic mode6 = 1'b0, out_ready6 = 1'b0, out_valid6;
  logic [2:0] sel6 = '0, out_sel6;
  logic [W-1:0] out_data6;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  muxnway_rr #(.WIDTH(W), .WAYS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MUXNWAY_RR_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  muxnway_rr #(.WIDTH(W), .WAYS(N6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
`ifdef MUXNWAY_RR_LOCK_EN
    .in_last('0), .out_last(),
`endif
    .mode(mode6), .sel(sel6), .out_data(out_data6), .out_valid(out_valid6),
    .out_ready(out_ready6), .out_sel(out_sel6)
  );

  // behavioural reference: which channel would be taken this cycle (-1 = none)
  logic m_valid;
  logic [W-1:0] m_data;
  int m_sel, m_ptr, m_lch = 0, mg;
  bit m_lock = 1'b0;

  function automatic int pick(input bit v, input int ptr, input bit lk, input int lch,
                              input bit md, input int s, input logic [N-1:0] iv, input bit ordy);
    if (v && !ordy) return -1;
    if (!md) return (s < N && iv[s]) ? s : -1;
    if (lk) return iv[lch] ? lch : -1;
    for (int k = 1; k <= N; k++) if (iv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  assign mg = pick(m_valid, m_ptr, m_lock, m_lch, mode, int'(sel), in_valid, out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_sel <= 0;
      m_ptr <= N - 1;
      m_lock <= 1'b0;
`ifdef MUXNWAY_RR_LOCK_EN
      m_last <= 1'b0;
`endif
    end else begin
      if (mg >= 0) begin
        m_valid <= 1'b1;
        m_data <= in_data[mg*W +: W];
        m_sel <= mg;
        if (mode) m_ptr <= mg;
`ifdef MUXNWAY_RR_LOCK_EN
        m_last <= in_last[mg];
`endif
      end else if (!m_valid || out_ready) m_valid <= 1'b0;
`ifdef MUXNWAY_RR_LOCK_EN
      if (!mode) m_lock <= 1'b0;
      else if (mg >= 0) begin
        m_lock <= !in_last[mg];
        m_lch <= mg;
      end
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d, expected 0/0000/0", out_valid, out_data, out_sel);
    end
    n_chk++;
    if (in_ready !== 8'h00 || out_valid6 !== 1'b0 || in_ready6 !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%h valid6=%b ready6=%h, expected 00/0/00", in_ready, out_valid6, in_ready6);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    sel = 3'd5;
    in_valid = 8'h20;
    in_data[5*W +: W] = 16'hBEEF;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 8'h20) begin
      n_fail++;
      $display("FAIL fixed_ready: got %h, expected 20", in_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_sel !== 3'd5) begin
      n_fail++;
      $display("FAIL fixed_capture: got valid=%b data=%h sel=%0d, expected 1/beef/5", out_valid, out_data, out_sel);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_rr_sweep();
    logic [N-1:0] e;
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'(i);
    for (int i = 0; i <= N; i++) begin
      #1;
      e = 8'h01 << (i % N);
      n_chk++;
      if (in_ready !== e) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %h, expected %h", i, in_ready, e);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 3'(i % N) || out_data !== 16'(i % N)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got valid=%b sel=%0d data=%h, expected 1/%0d/%0d", i, out_valid, out_sel, out_data, i % N, i % N);
      end
      @(negedge clk);
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'h81;
    in_data[0 +: W] = 16'h00A0;
    in_data[7*W +: W] = 16'h00A7;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 16'h00A0) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b sel=%0d data=%h, expected 1/0/00a0", out_valid, out_sel, out_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (in_ready !== 8'h00) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: got %h, expected 00", c, in_ready);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 3'd0 || out_data !== 16'h00A0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b sel=%0d data=%h, expected 1/0/00a0", c, out_valid, out_sel, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 8'h80) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %h, expected 80", in_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_sel !== 3'd7 || out_data !== 16'h00A7) begin
      n_fail++;
      $display("FAIL bp_next7: got sel=%0d data=%h, expected 7/00a7", out_sel, out_data);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_sel !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next0: got sel=%0d valid=%b, expected 0/1", out_sel, out_valid);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_sel_oob();
    mode6 = 1'b0;
    out_ready6 = 1'b1;
    in_valid6 = 6'h3F;
    in_data6[5*W +: W] = 16'h5555;
    for (int c = 0; c < 10; c++) begin
      sel6 = (c % 2 == 0) ? 3'd7 : 3'd6;
      #1;
      n_chk++;
      if (in_ready6 !== 6'h00) begin
        n_fail++;
        $display("FAIL oob_ready[%0d]: got %h, expected 00 (sel=%0d)", c, in_ready6, sel6);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid6 !== 1'b0) begin
        n_fail++;
        $display("FAIL oob_valid[%0d]: got %b, expected 0", c, out_valid6);
      end
      @(negedge clk);
    end
    sel6 = 3'd5;
    #1;
    n_chk++;
    if (in_ready6 !== 6'h20) begin
      n_fail++;
      $display("FAIL six_ready: got %h, expected 20", in_ready6);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid6 !== 1'b1 || out_sel6 !== 3'd5 || out_data6 !== 16'h5555) begin
      n_fail++;
      $display("FAIL six_capture: got valid=%b sel=%0d data=%h, expected 1/5/5555", out_valid6, out_sel6, out_data6);
    end
    @(negedge clk);
    in_valid6 = '0;
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    sel = 3'd3;
    in_valid = 8'h08;
    in_data[3*W +: W] = 16'h1234;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_sel !== 3'd3) begin
      n_fail++;
      $display("FAIL ar_load: got valid=%b data=%h sel=%0d, expected 1/1234/3", out_valid, out_data, out_sel);
    end
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL ar_clear: got valid=%b data=%h sel=%0d, expected 0/0000/0", out_valid, out_data, out_sel);
    end
    rst_n = 1'b1;
    mode = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 8'h01) begin
      n_fail++;
      $display("FAIL ar_first_ready: got %h, expected 01", in_ready);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL ar_first_grant: got valid=%b sel=%0d, expected 1/0", out_valid, out_sel);
    end
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      mode = ($urandom_range(0, 3) != 0);
      sel = 3'($urandom);
      in_valid = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = {$urandom, $urandom, $urandom, $urandom};
`ifdef MUXNWAY_RR_LOCK_EN
      in_last = 8'($urandom);
`endif
      #1;
      e = '0;
      if (mg >= 0) e[mg] = 1'b1;
      n_chk++;
      if (in_ready !== e) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %h, expected %h", c, in_ready, e);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== m_valid || out_data !== m_data || out_sel !== 3'(m_sel)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h sel=%0d, expected %b/%h/%0d", c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
`ifdef MUXNWAY_RR_LOCK_EN
      n_chk++;
      if (out_last !== m_last) begin
        n_fail++;
        $display("FAIL rand_last[%0d]: got %b, expected %b", c, out_last, m_last);
      end
`endif
    end
    @(negedge clk);
    in_valid = '0;
  endtask

`ifdef MUXNWAY_RR_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] iv [5] = '{8'h0C, 8'h08, 8'h0C, 8'h0C, 8'h08};
    logic [N-1:0] il [5] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    logic [N-1:0] er [5] = '{8'h04, 8'h00, 8'h04, 8'h04, 8'h08};
    logic ev [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] es [5] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    logic el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mode = 1'b1;
    out_ready = 1'b1;
    in_data[3*W +: W] = 16'h3000;
    for (int b = 0; b < 5; b++) begin
      in_valid = iv[b];
      in_last = il[b];
      in_data[2*W +: W] = 16'h2000 + 16'(b);
      #1;
      n_chk++;
      if (in_ready !== er[b]) begin
        n_fail++;
        $display("FAIL lock_ready[%0d]: got %h, expected %h", b, in_ready, er[b]);
      end
      @(posedge clk); #1;
      n_chk++;
      if (out_valid !== ev[b] || out_sel !== es[b] || (ev[b] && out_last !== el[b])) begin
        n_fail++;
        $display("FAIL lock_out[%0d]: got valid=%b sel=%0d last=%b, expected %b/%0d/%b", b, out_valid, out_sel, out_last, ev[b], es[b], el[b]);
      end
      @(negedge clk);
    end
    in_valid = '0;
    in_last = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr_sweep();
    test_backpressure();
    test_sel_oob();
    test_async_reset();
`ifdef MUXNWAY_RR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
